// File: rtl/alu_issue_pkg.sv
// Shared opcode, funct and ALU control constants plus the decoded
// instruction bundle carried through the issue buffer.
package alu_issue_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [5:0] ALU_NOP = 6'b000000;
    localparam logic [5:0] ALU_ADD = 6'b100000;
    localparam logic [5:0] ALU_BR  = 6'b000101;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef struct packed {
        logic [5:0]  alu_op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic        reg_write;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
        logic        branch_ne;
        logic        jump;
        logic        jr;
        logic        illegal;
    } dec_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/alu_issue_stage_alu_ctrl_decode.sv
// Combinational decode of one ID-stage instruction into ALU operands,
// ALU control code and writeback/memory/control-flow flags.
module alu_ctrl_decode
    import alu_issue_pkg::*;
(
    input  logic [5:0]  i_opcode,
    input  logic [5:0]  i_funct,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    input  logic [15:0] i_imm,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rt,
    output dec_t        o_dec
);

    always_comb begin
        o_dec   = '0;
        o_dec.a = i_rs_data;
        unique case (1'b1)
            (i_opcode == OP_RTYPE): begin
                unique case (i_funct)
                    // ALU control codes equal the funct encodings
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_NOR: begin
                        o_dec.alu_op    = i_funct;
                        o_dec.b         = i_rt_data;
                        o_dec.dest      = i_rd;
                        o_dec.reg_write = 1'b1;
                    end
                    FN_JR: begin
                        o_dec.alu_op = ALU_ADD;
                        o_dec.jr     = 1'b1;
                    end
                    default: o_dec.illegal = 1'b1;
                endcase
            end
            (i_opcode == OP_ADDI): begin
                o_dec.alu_op    = ALU_ADD;
                o_dec.b         = sext16(i_imm);
                o_dec.dest      = i_rt;
                o_dec.reg_write = 1'b1;
            end
            (i_opcode == OP_LW): begin
                o_dec.alu_op    = ALU_ADD;
                o_dec.b         = sext16(i_imm);
                o_dec.dest      = i_rt;
                o_dec.reg_write = 1'b1;
                o_dec.mem_rd    = 1'b1;
            end
            (i_opcode == OP_SW): begin
                o_dec.alu_op = ALU_ADD;
                o_dec.b      = sext16(i_imm);
                o_dec.mem_wr = 1'b1;
            end
            (i_opcode == OP_BEQ), (i_opcode == OP_BNE): begin
                o_dec.alu_op    = ALU_BR;
                o_dec.b         = i_rt_data;
                o_dec.branch    = 1'b1;
                o_dec.branch_ne = (i_opcode == OP_BNE);
            end
            (i_opcode == OP_J): begin
                o_dec.jump = 1'b1;
            end
            (i_opcode == OP_JAL): begin
                o_dec.jump      = 1'b1;
                o_dec.dest      = REG_RA;
                o_dec.reg_write = 1'b1;
            end
            default: o_dec.illegal = 1'b1;
        endcase
        if (o_dec.dest == 5'd0)
            o_dec.reg_write = 1'b0;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode plus a two-entry (main + skid) buffer with a
// registered id_ready so the upstream handshake has no comb path from EX.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [5:0]        id_opcode,
    input  logic [5:0]        id_funct,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [15:0]       id_imm,
    input  logic [4:0]        id_rd,
    input  logic [4:0]        id_rt,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [DATA_W-1:0] outRegA,
    output logic [DATA_W-1:0] outRegB,
    output logic [5:0]        ALUControlOpcode,
    output logic [4:0]        ex_dest,
    output logic              ex_reg_write,
    output logic              ex_mem_rd,
    output logic              ex_mem_wr,
    output logic              ex_branch,
    output logic              ex_branch_ne,
    output logic              ex_jump,
    output logic              ex_jr,
    output logic              ex_illegal
);

    dec_t w_dec;
    dec_t r_main;
    dec_t r_skid;
    dec_t w_main_n;
    dec_t w_skid_n;
    logic r_main_v;
    logic r_skid_v;
    logic r_id_ready;
    logic w_main_v_n;
    logic w_skid_v_n;
    logic w_accept;
    logic w_pop;

    alu_ctrl_decode u_dec (
        .i_opcode  (id_opcode),
        .i_funct   (id_funct),
        .i_rs_data (id_rs_data),
        .i_rt_data (id_rt_data),
        .i_imm     (id_imm),
        .i_rd      (id_rd),
        .i_rt      (id_rt),
        .o_dec     (w_dec)
    );

    assign w_accept = id_valid && r_id_ready;
    assign w_pop    = r_main_v && ex_ready;

    always_comb begin
        w_main_n   = r_main;
        w_skid_n   = r_skid;
        w_main_v_n = r_main_v;
        w_skid_v_n = r_skid_v;
        if (flush) begin
            w_main_n   = '0;
            w_skid_n   = '0;
            w_main_v_n = 1'b0;
            w_skid_v_n = 1'b0;
        end else if (r_skid_v) begin
            // id_ready is low here, so no new accept can arrive
            if (w_pop) begin
                w_main_n   = r_skid;
                w_skid_v_n = 1'b0;
            end
        end else if (!r_main_v || w_pop) begin
            w_main_v_n = w_accept;
            if (w_accept)
                w_main_n = w_dec;
        end else if (w_accept) begin
            w_skid_n   = w_dec;
            w_skid_v_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main     <= '0;
            r_skid     <= '0;
            r_main_v   <= 1'b0;
            r_skid_v   <= 1'b0;
            r_id_ready <= 1'b1;
        end else begin
            r_main     <= w_main_n;
            r_skid     <= w_skid_n;
            r_main_v   <= w_main_v_n;
            r_skid_v   <= w_skid_v_n;
            r_id_ready <= !w_skid_v_n;
        end
    end

    assign id_ready         = r_id_ready;
    assign ex_valid         = r_main_v;
    assign outRegA          = r_main.a;
    assign outRegB          = r_main.b;
    assign ALUControlOpcode = r_main.alu_op;
    assign ex_dest          = r_main.dest;
    assign ex_reg_write     = r_main.reg_write;
    assign ex_mem_rd        = r_main.mem_rd;
    assign ex_mem_wr        = r_main.mem_wr;
    assign ex_branch        = r_main.branch;
    assign ex_branch_ne     = r_main.branch_ne;
    assign ex_jump          = r_main.jump;
    assign ex_jr            = r_main.jr;
    assign ex_illegal       = r_main.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, stall/skid,
// flush and asynchronous reset behaviour.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [5:0]  id_opcode;
    logic [5:0]  id_funct;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [15:0] id_imm;
    logic [4:0]  id_rd;
    logic [4:0]  id_rt;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] outRegA;
    logic [31:0] outRegB;
    logic [5:0]  ALUControlOpcode;
    logic [4:0]  ex_dest;
    logic        ex_reg_write;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic        ex_branch;
    logic        ex_branch_ne;
    logic        ex_jump;
    logic        ex_jr;
    logic        ex_illegal;

    int n_pass  = 0;
    int n_total = 0;

    alu_issue_stage #(.DATA_W(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_valid         (id_valid),
        .id_ready         (id_ready),
        .id_opcode        (id_opcode),
        .id_funct         (id_funct),
        .id_rs_data       (id_rs_data),
        .id_rt_data       (id_rt_data),
        .id_imm           (id_imm),
        .id_rd            (id_rd),
        .id_rt            (id_rt),
        .flush            (flush),
        .ex_ready         (ex_ready),
        .ex_valid         (ex_valid),
        .outRegA          (outRegA),
        .outRegB          (outRegB),
        .ALUControlOpcode (ALUControlOpcode),
        .ex_dest          (ex_dest),
        .ex_reg_write     (ex_reg_write),
        .ex_mem_rd        (ex_mem_rd),
        .ex_mem_wr        (ex_mem_wr),
        .ex_branch        (ex_branch),
        .ex_branch_ne     (ex_branch_ne),
        .ex_jump          (ex_jump),
        .ex_jr            (ex_jr),
        .ex_illegal       (ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic offer(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [15:0] imm, input logic [4:0] rd,
                         input logic [4:0] rtf);
        id_valid   = 1'b1;
        id_opcode  = op;
        id_funct   = fn;
        id_rs_data = rs;
        id_rt_data = rt;
        id_imm     = imm;
        id_rd      = rd;
        id_rt      = rtf;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        id_opcode = '0; id_funct = '0; id_rs_data = '0; id_rt_data = '0;
        id_imm = '0; id_rd = '0; id_rt = '0;
        #12;
        n_total++;
        if (ex_valid !== 1'b0)
            $display("FAIL reset_ex_valid got %b want 0", ex_valid);
        else n_pass++;
        n_total++;
        if (id_ready !== 1'b1)
            $display("FAIL reset_id_ready got %b want 1", id_ready);
        else n_pass++;
        n_total++;
        if (ALUControlOpcode !== 6'b0)
            $display("FAIL reset_code got %b want 000000", ALUControlOpcode);
        else n_pass++;
        n_total++;
        if (outRegA !== 32'h0 || outRegB !== 32'h0)
            $display("FAIL reset_operands got %h/%h want 0/0", outRegA, outRegB);
        else n_pass++;
        n_total++;
        if ({ex_dest, ex_reg_write, ex_mem_rd, ex_mem_wr, ex_branch, ex_branch_ne,
             ex_jump, ex_jr, ex_illegal} !== 13'h0)
            $display("FAIL reset_controls got nonzero controls want 0");
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        ex_ready = 1'b1;
        offer(6'b000000, 6'b100000, 32'd5, 32'd7, 16'h0, 5'd3, 5'd2);
        step();
        id_valid = 1'b0;
        n_total++;
        if (ex_valid !== 1'b1) $display("FAIL add_valid got %b want 1", ex_valid);
        else n_pass++;
        n_total++;
        if (ALUControlOpcode !== 6'b100000)
            $display("FAIL add_code got %b want 100000", ALUControlOpcode);
        else n_pass++;
        n_total++;
        if (outRegA !== 32'd5 || outRegB !== 32'd7)
            $display("FAIL add_operands got %0d/%0d want 5/7", outRegA, outRegB);
        else n_pass++;
        n_total++;
        if (ex_dest !== 5'd3 || ex_reg_write !== 1'b1)
            $display("FAIL add_dest got %0d/%b want 3/1", ex_dest, ex_reg_write);
        else n_pass++;
        step();
        n_total++;
        if (ex_valid !== 1'b0) $display("FAIL add_drain got %b want 0", ex_valid);
        else n_pass++;
        offer(6'b000000, 6'b100010, 32'd9, 32'd4, 16'h0, 5'd0, 5'd1);
        step();
        id_valid = 1'b0;
        n_total++;
        if (ALUControlOpcode !== 6'b100010 || ex_reg_write !== 1'b0)
            $display("FAIL sub_r0 got %b/%b want 100010/0", ALUControlOpcode, ex_reg_write);
        else n_pass++;
        step();
    endtask

    task automatic test_imm_mem();
        offer(6'b001000, 6'b000000, 32'd10, 32'd99, 16'hFFFC, 5'd1, 5'd9);
        step();
        n_total++;
        if (outRegB !== 32'hFFFFFFFC || outRegA !== 32'd10)
            $display("FAIL addi_operands got %h/%h want 0000000a/fffffffc", outRegA, outRegB);
        else n_pass++;
        n_total++;
        if (ALUControlOpcode !== 6'b100000 || ex_dest !== 5'd9 || ex_reg_write !== 1'b1)
            $display("FAIL addi_ctrl got %b/%0d/%b want 100000/9/1",
                     ALUControlOpcode, ex_dest, ex_reg_write);
        else n_pass++;
        offer(6'b100011, 6'b000000, 32'd100, 32'd0, 16'h0010, 5'd0, 5'd4);
        step();
        n_total++;
        if (outRegB !== 32'h10 || ex_mem_rd !== 1'b1 || ex_dest !== 5'd4 || ex_reg_write !== 1'b1)
            $display("FAIL lw got B=%h rd=%b dest=%0d wr=%b want 10/1/4/1",
                     outRegB, ex_mem_rd, ex_dest, ex_reg_write);
        else n_pass++;
        offer(6'b101011, 6'b000000, 32'd100, 32'd55, 16'h8000, 5'd0, 5'd6);
        step();
        id_valid = 1'b0;
        n_total++;
        if (outRegB !== 32'hFFFF8000 || ex_mem_wr !== 1'b1 || ex_reg_write !== 1'b0 || ex_mem_rd !== 1'b0)
            $display("FAIL sw got B=%h mw=%b wr=%b mr=%b want ffff8000/1/0/0",
                     outRegB, ex_mem_wr, ex_reg_write, ex_mem_rd);
        else n_pass++;
        step();
    endtask

    task automatic test_ctrl_flow();
        offer(6'b000101, 6'b000000, 32'd1, 32'd2, 16'h0004, 5'd0, 5'd2);
        step();
        n_total++;
        if (ALUControlOpcode !== 6'b000101 || ex_branch !== 1'b1 || ex_branch_ne !== 1'b1 || outRegB !== 32'd2)
            $display("FAIL bne got %b/%b/%b B=%0d want 000101/1/1/2",
                     ALUControlOpcode, ex_branch, ex_branch_ne, outRegB);
        else n_pass++;
        offer(6'b000100, 6'b000000, 32'd1, 32'd2, 16'h0004, 5'd0, 5'd2);
        step();
        n_total++;
        if (ex_branch !== 1'b1 || ex_branch_ne !== 1'b0)
            $display("FAIL beq got %b/%b want 1/0", ex_branch, ex_branch_ne);
        else n_pass++;
        offer(6'b111111, 6'b100000, 32'd3, 32'd4, 16'h0001, 5'd7, 5'd7);
        step();
        n_total++;
        if (ex_illegal !== 1'b1 || ALUControlOpcode !== 6'b0 || ex_reg_write !== 1'b0
            || ex_mem_wr !== 1'b0 || ex_mem_rd !== 1'b0 || ex_valid !== 1'b1)
            $display("FAIL illegal got ill=%b code=%b wr=%b mw=%b mr=%b v=%b want 1/000000/0/0/0/1",
                     ex_illegal, ALUControlOpcode, ex_reg_write, ex_mem_wr, ex_mem_rd, ex_valid);
        else n_pass++;
        offer(6'b000011, 6'b000000, 32'd8, 32'd4, 16'h0001, 5'd0, 5'd0);
        step();
        n_total++;
        if (ex_jump !== 1'b1 || ex_dest !== 5'd31 || ex_reg_write !== 1'b1
            || ALUControlOpcode !== 6'b0 || ex_illegal !== 1'b0)
            $display("FAIL jal got j=%b dest=%0d wr=%b code=%b ill=%b want 1/31/1/000000/0",
                     ex_jump, ex_dest, ex_reg_write, ALUControlOpcode, ex_illegal);
        else n_pass++;
        offer(6'b000000, 6'b001000, 32'h40, 32'd4, 16'h0, 5'd0, 5'd0);
        step();
        id_valid = 1'b0;
        n_total++;
        if (ex_jr !== 1'b1 || ALUControlOpcode !== 6'b100000 || outRegB !== 32'h0 || outRegA !== 32'h40)
            $display("FAIL jr got jr=%b code=%b A=%h B=%h want 1/100000/40/0",
                     ex_jr, ALUControlOpcode, outRegA, outRegB);
        else n_pass++;
        step();
    endtask

    task automatic test_back_to_back_stall();
        ex_ready = 1'b0;
        offer(6'b000000, 6'b100000, 32'd1, 32'd11, 16'h0, 5'd5, 5'd0);
        step();
        n_total++;
        if (ex_valid !== 1'b1 || outRegA !== 32'd1 || id_ready !== 1'b1)
            $display("FAIL stall_first got v=%b A=%0d rdy=%b want 1/1/1", ex_valid, outRegA, id_ready);
        else n_pass++;
        offer(6'b000000, 6'b100100, 32'd2, 32'd12, 16'h0, 5'd6, 5'd0);
        step();
        n_total++;
        if (id_ready !== 1'b0 || outRegA !== 32'd1 || outRegB !== 32'd11)
            $display("FAIL stall_skid got rdy=%b A=%0d B=%0d want 0/1/11", id_ready, outRegA, outRegB);
        else n_pass++;
        offer(6'b000000, 6'b100101, 32'd3, 32'd13, 16'h0, 5'd7, 5'd0);
        step();
        n_total++;
        if (id_ready !== 1'b0 || outRegA !== 32'd1 || ALUControlOpcode !== 6'b100000 || ex_dest !== 5'd5)
            $display("FAIL stall_hold got rdy=%b A=%0d code=%b dest=%0d want 0/1/100000/5",
                     id_ready, outRegA, ALUControlOpcode, ex_dest);
        else n_pass++;
        ex_ready = 1'b1;
        step();
        n_total++;
        if (ex_valid !== 1'b1 || outRegA !== 32'd2 || ALUControlOpcode !== 6'b100100 || id_ready !== 1'b1)
            $display("FAIL stall_second got v=%b A=%0d code=%b rdy=%b want 1/2/100100/1",
                     ex_valid, outRegA, ALUControlOpcode, id_ready);
        else n_pass++;
        step();
        id_valid = 1'b0;
        n_total++;
        if (ex_valid !== 1'b1 || outRegA !== 32'd3 || ALUControlOpcode !== 6'b100101)
            $display("FAIL stall_third got v=%b A=%0d code=%b want 1/3/100101",
                     ex_valid, outRegA, ALUControlOpcode);
        else n_pass++;
        step();
        n_total++;
        if (ex_valid !== 1'b0) $display("FAIL stall_drain got %b want 0", ex_valid);
        else n_pass++;
    endtask

    task automatic test_flush();
        ex_ready = 1'b0;
        offer(6'b000000, 6'b100000, 32'd1, 32'd0, 16'h0, 5'd5, 5'd0);
        step();
        offer(6'b000000, 6'b100000, 32'd2, 32'd0, 16'h0, 5'd5, 5'd0);
        step();
        n_total++;
        if (id_ready !== 1'b0 || ex_valid !== 1'b1)
            $display("FAIL flush_fill got rdy=%b v=%b want 0/1", id_ready, ex_valid);
        else n_pass++;
        offer(6'b000000, 6'b100000, 32'd4, 32'd0, 16'h0, 5'd5, 5'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        id_valid = 1'b0;
        n_total++;
        if (ex_valid !== 1'b0 || id_ready !== 1'b1)
            $display("FAIL flush_clear got v=%b rdy=%b want 0/1", ex_valid, id_ready);
        else n_pass++;
        ex_ready = 1'b1;
        step();
        n_total++;
        if (ex_valid !== 1'b0) $display("FAIL flush_no_skid got %b want 0", ex_valid);
        else n_pass++;
        offer(6'b000000, 6'b100000, 32'd8, 32'd0, 16'h0, 5'd5, 5'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        id_valid = 1'b0;
        n_total++;
        if (ex_valid !== 1'b0)
            $display("FAIL flush_drop_accept got %b want 0", ex_valid);
        else n_pass++;
        step();
    endtask

    task automatic test_async_reset();
        ex_ready = 1'b0;
        offer(6'b000000, 6'b100000, 32'd1, 32'd21, 16'h0, 5'd5, 5'd0);
        step();
        offer(6'b000000, 6'b100000, 32'd2, 32'd22, 16'h0, 5'd5, 5'd0);
        step();
        id_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (ex_valid !== 1'b0 || id_ready !== 1'b1)
            $display("FAIL areset_flags got v=%b rdy=%b want 0/1", ex_valid, id_ready);
        else n_pass++;
        n_total++;
        if (outRegA !== 32'h0 || outRegB !== 32'h0 || ALUControlOpcode !== 6'b0 || ex_reg_write !== 1'b0)
            $display("FAIL areset_outputs got A=%h B=%h code=%b wr=%b want 0/0/000000/0",
                     outRegA, outRegB, ALUControlOpcode, ex_reg_write);
        else n_pass++;
        ex_ready = 1'b1;
        offer(6'b001000, 6'b000000, 32'd9, 32'd0, 16'h0002, 5'd0, 5'd3);
        #1 rst_n = 1'b1;
        step();
        id_valid = 1'b0;
        n_total++;
        if (ex_valid !== 1'b1 || outRegA !== 32'd9 || outRegB !== 32'd2)
            $display("FAIL areset_first_accept got v=%b A=%0d B=%0d want 1/9/2",
                     ex_valid, outRegA, outRegB);
        else n_pass++;
        step();
        n_total++;
        if (ex_valid !== 1'b0)
            $display("FAIL areset_no_ghost got %b want 0", ex_valid);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_imm_mem();
        test_ctrl_flow();
        test_back_to_back_stall();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; must stay 32.
REQ-002 clk  in  1  rising-edge clock, single clock domain.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 id_valid  in  1  ID stage offers an instruction.
REQ-005 id_ready  out  1  stage accepts; transfer when id_valid && id_ready.
REQ-006 id_opcode / id_funct  in  6 / 6  instruction [31:26] / [5:0].
REQ-007 id_rs_data / id_rt_data  in  32 / 32  register-file read data.
REQ-008 id_imm / id_rd / id_rt  in  16 / 5 / 5  immediate, rd, rt fields.
REQ-009 flush  in  1  branch or jump squash.
REQ-010 ex_ready  in  1  EX consumes the presented instruction.
REQ-011 ex_valid  out  1  outputs below are meaningful.
REQ-012 outRegA / outRegB  out  32 / 32  ALU operands.
REQ-013 ALUControlOpcode  out  6  ALU operation code.
REQ-014 ex_dest / ex_reg_write / ex_mem_rd / ex_mem_wr  out  5 / 1 / 1 / 1  writeback and memory controls.
REQ-015 ex_branch / ex_branch_ne / ex_jump / ex_jr  out  1 each  control-flow class.
REQ-016 ex_illegal  out  1  unsupported encoding; the slot travels as a no-op.

Function
REQ-017 Decode (ALUControlOpcode, B operand):
- R-type opcode 000000:
  - add 100000 -> 100000; sub 100010 -> 100010; and 100100 -> 100100; or 100101 -> 100101; slt 101010 -> 101010; nor 100111 -> 100111; all use B = rt_data.
  - jr 001000 -> 100000 with B = 0, ex_jr = 1.
- addi 001000 -> 100000, B = sign-extended imm, dest rt.
- lw 100011 / sw 101011 -> 100000, B = sign-extended imm.
- beq 000100 / bne 000101 -> 000101, B = rt_data; ex_branch_ne = 1 for bne only.
- j 000010 / jal 000011 -> 000000; jal: dest 31, reg_write = 1.
REQ-018 Writes: R-type ALU ops write rd; lw writes rt and sets mem_rd; sw sets mem_wr with no write; writes to register 0 force ex_reg_write = 0.
REQ-019 Any other encoding: code 000000, every control 0, ex_illegal = 1.
REQ-020 outRegA = rs_data for every instruction.
REQ-021 Buffering is two entries: main register (drives outputs) and skid register; latency ID to EX = 1 cycle.
REQ-022 id_ready is registered: 1 if and only if skid is empty.
REQ-023 Accept goes to main when main is empty, or is emptying this cycle with skid empty; otherwise it goes to skid.
REQ-024 ex_valid && !ex_ready: main and all outputs hold stable.
REQ-025 ex_ready with skid full: skid moves to main, skid empties, id_ready rises next cycle.
REQ-026 flush clears main and skid and drops that cycle's accept; flush has priority over every other event.
REQ-027 Order is preserved; no instruction is duplicated or lost absent flush.

Reset
REQ-028 Reset clears all state asynchronously:
- ex_valid = 0, id_ready = 1, skid empty.
- ALUControlOpcode = 000000, outRegA = outRegB = 0, every control output = 0.
REQ-029 Reset asserted mid-transfer discards both entries; first accept allowed on the first edge after deassertion.

Structure
REQ-030 Shared package holds opcode, funct and ALU control code constants, reused by the ALU.
REQ-031 Combinational decoder is a sub-module, alu_ctrl_decode; buffer logic sits in the top module.

Verification
REQ-032 Scenario: add rs = 5, rt = 7, rd = 3, ex_ready = 1 -> next cycle ex_valid = 1, code 100000, A = 5, B = 7, dest 3, reg_write = 1.
REQ-033 Scenario: addi imm = 0xFFFC, rs = 10 -> B = 0xFFFFFFFC, dest = rt, code 100000.
REQ-034 Scenario: ex_ready = 0 for 3 cycles with id_valid held -> second instruction goes to skid, id_ready = 0, outputs stable; ex_ready = 1 -> both instructions delivered in order on consecutive cycles.
REQ-035 Scenario: flush with main and skid both full -> next cycle ex_valid = 0, id_ready = 1, offered instruction dropped.
REQ-036 Scenario: opcode 111111 -> ex_illegal = 1, code 000000, all writes 0; bne -> code 000101, ex_branch = ex_branch_ne = 1.
REQ-037 Scenario: rst_n low mid-stall -> outputs reset immediately without a clock edge.
